// File: rtl/jtdsp16_pkg.sv
// jtdsp16_pkg
// Shared definitions for the JTDSP16 program sequencer:
//   - b_op_e  : subtype carried in b_field with goto_b (values 4-7 are no-ops)
//   - xreg_e  : register selected by r_field for imm_load/ram_load
//   - pc_src_e: where the next PC comes from, in priority order
//   - DEF_RST_VEC / DEF_IRQ_VEC: default reset and interrupt vectors
package jtdsp16_pkg;

  typedef enum logic [2:0] {
    B_RET    = 3'd0,
    B_IRET   = 3'd1,
    B_GOPT   = 3'd2,
    B_CALLPT = 3'd3
  } b_op_e;

  typedef enum logic [2:0] {
    XR_PT = 3'd0,
    XR_PR = 3'd1,
    XR_PI = 3'd2,
    XR_I  = 3'd3
  } xreg_e;

  typedef enum logic [2:0] {
    PC_SRC_INC  = 3'd0,
    PC_SRC_HOLD = 3'd1,
    PC_SRC_IRQ  = 3'd2,
    PC_SRC_JA   = 3'd3,
    PC_SRC_PR   = 3'd4,
    PC_SRC_PI   = 3'd5,
    PC_SRC_PT   = 3'd6
  } pc_src_e;

  localparam logic [15:0] DEF_RST_VEC = 16'h0000;
  localparam logic [15:0] DEF_IRQ_VEC = 16'h0001;

  // Sign-extend the 12-bit increment register to the 16-bit address width.
  function automatic logic [15:0] sext_i(input logic [11:0] inc);
    return {{4{inc[11]}}, inc};
  endfunction

endpackage

// File: rtl/jtdsp16_pcseq_if.sv
// jtdsp16_pcseq_if
// Bundle between the instruction decoder (master) and the program
// sequencer (slave).
//   Decoder -> sequencer: goto_ja, call_ja, goto_b, b_field, i_field,
//                         pc_halt, imm_load, ram_load, r_field, load_data,
//                         pt_inc, irq (external request routed alongside)
//   Sequencer -> decoder: rom_addr, pr, pi, pt, i_reg, in_irq, irq_ack
interface jtdsp16_pcseq_if;

  logic        goto_ja;
  logic        call_ja;
  logic        goto_b;
  logic [2:0]  b_field;
  logic [11:0] i_field;
  logic        pc_halt;
  logic        imm_load;
  logic        ram_load;
  logic [2:0]  r_field;
  logic [15:0] load_data;
  logic        pt_inc;
  logic        irq;

  logic [15:0] rom_addr;
  logic [15:0] pr;
  logic [15:0] pi;
  logic [15:0] pt;
  logic [11:0] i_reg;
  logic        in_irq;
  logic        irq_ack;

  modport master (
    output goto_ja, call_ja, goto_b, b_field, i_field, pc_halt,
           imm_load, ram_load, r_field, load_data, pt_inc, irq,
    input  rom_addr, pr, pi, pt, i_reg, in_irq, irq_ack
  );

  modport slave (
    input  goto_ja, call_ja, goto_b, b_field, i_field, pc_halt,
           imm_load, ram_load, r_field, load_data, pt_inc, irq,
    output rom_addr, pr, pi, pt, i_reg, in_irq, irq_ack
  );

endinterface

// File: rtl/jtdsp16_ptadd.sv
// jtdsp16_ptadd
// PT post-increment adder: sum = pt + sext(inc), modulo 2^16.
// Kept separate so the table-read path can reuse it.
//   pt  in  16  current table pointer
//   inc in  12  signed increment (I register)
//   sum out 16  incremented pointer
module jtdsp16_ptadd
  import jtdsp16_pkg::*;
(
  input  logic [15:0] pt,
  input  logic [11:0] inc,
  output logic [15:0] sum
);

  assign sum = pt + sext_i(inc);

endmodule

// File: rtl/jtdsp16_pcseq.sv
// jtdsp16_pcseq
// Program sequencer for the JTDSP16 core. Owns PC, PR, PI, PT and I,
// drives the program ROM address and handles external interrupt entry.
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   cen    in  clock enable qualifying every state update
//   bus    slave side of jtdsp16_pcseq_if (decoder strobes in,
//          rom_addr / register contents / interrupt status out)
// Parameters: RST_VEC (PC after reset), IRQ_VEC (PC on interrupt entry).
module jtdsp16_pcseq
  import jtdsp16_pkg::*;
#(
  parameter logic [15:0] RST_VEC = DEF_RST_VEC,
  parameter logic [15:0] IRQ_VEC = DEF_IRQ_VEC
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cen,
  jtdsp16_pcseq_if.slave    bus
);

  logic [15:0] pc, pr, pi, pt;
  logic [11:0] i_reg;
  logic        in_irq, irq_ack, slot;

  logic [15:0] pc_nxt, pr_nxt, pi_nxt, pt_nxt;
  logic [11:0] i_nxt;
  logic        in_irq_nxt, irq_ack_nxt, slot_nxt;

  logic [15:0] pt_sum;
  pc_src_e     pc_src;

  logic ja_jump, b_jump, any_jump;
  logic is_call, is_iret, irq_take, load_en;

  jtdsp16_ptadd u_ptadd (
    .pt  (pt),
    .inc (i_reg),
    .sum (pt_sum)
  );

  // Strobe decode. goto_b only counts as a jump for subtypes 0-3; the
  // B-type subtypes (ireturn, call PT) are only honoured when no J-type
  // jump is present, since call_ja/goto_ja outrank goto_b.
  always_comb begin
    ja_jump  = bus.call_ja | bus.goto_ja;
    b_jump   = bus.goto_b & ~bus.b_field[2];
    any_jump = ja_jump | b_jump;
    is_call  = bus.call_ja | (b_jump & ~ja_jump & (bus.b_field == B_CALLPT));
    is_iret  = b_jump & ~ja_jump & (bus.b_field == B_IRET);
    // The word fetched in the slot after a jump is discarded, so an
    // interrupt taken there would save a bogus return address.
    irq_take = bus.irq & ~in_irq & ~slot & ~any_jump & ~bus.pc_halt;
    load_en  = bus.imm_load | bus.ram_load;
  end

  // Select the PC source: jumps beat interrupt entry, which beats halt.
  always_comb begin
    pc_src = PC_SRC_INC;
    if (ja_jump) begin
      pc_src = PC_SRC_JA;
    end else if (b_jump) begin
      case (bus.b_field[1:0])
        2'd0:    pc_src = PC_SRC_PR;
        2'd1:    pc_src = PC_SRC_PI;
        default: pc_src = PC_SRC_PT;
      endcase
    end else if (irq_take) begin
      pc_src = PC_SRC_IRQ;
    end else if (bus.pc_halt) begin
      pc_src = PC_SRC_HOLD;
    end
  end

  always_comb begin
    pc_nxt = pc + 16'd1;
    case (pc_src)
      PC_SRC_JA:   pc_nxt = {pc[15:12], bus.i_field};
      PC_SRC_PR:   pc_nxt = pr;
      PC_SRC_PI:   pc_nxt = pi;
      PC_SRC_PT:   pc_nxt = pt;
      PC_SRC_IRQ:  pc_nxt = IRQ_VEC;
      PC_SRC_HOLD: pc_nxt = pc;
      default:     pc_nxt = pc + 16'd1;
    endcase
  end

  // Register file updates. Loads land first; a call then overrides a PR
  // load and interrupt entry overrides a PI load.
  always_comb begin
    pr_nxt = pr;
    pi_nxt = pi;
    pt_nxt = pt;
    i_nxt  = i_reg;

    if (load_en) begin
      case (bus.r_field)
        XR_PT:   pt_nxt = bus.load_data;
        XR_PR:   pr_nxt = bus.load_data;
        XR_PI:   pi_nxt = bus.load_data;
        XR_I:    i_nxt  = bus.load_data[11:0];
        default: ;
      endcase
    end

    if (bus.pt_inc && !(load_en && bus.r_field == XR_PT)) begin
      pt_nxt = pt_sum;
    end

    if (is_call) begin
      pr_nxt = pc;
    end

    if (irq_take) begin
      pi_nxt = pc;
    end
  end

  always_comb begin
    in_irq_nxt = in_irq;
    if (irq_take) begin
      in_irq_nxt = 1'b1;
    end else if (is_iret) begin
      in_irq_nxt = 1'b0;
    end
    irq_ack_nxt = irq_take;
    slot_nxt    = any_jump;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc      <= RST_VEC;
      pr      <= 16'h0000;
      pi      <= 16'h0000;
      pt      <= 16'h0000;
      i_reg   <= 12'h000;
      in_irq  <= 1'b0;
      irq_ack <= 1'b0;
      slot    <= 1'b0;
    end else if (cen) begin
      pc      <= pc_nxt;
      pr      <= pr_nxt;
      pi      <= pi_nxt;
      pt      <= pt_nxt;
      i_reg   <= i_nxt;
      in_irq  <= in_irq_nxt;
      irq_ack <= irq_ack_nxt;
      slot    <= slot_nxt;
    end
  end

  assign bus.rom_addr = pc;
  assign bus.pr       = pr;
  assign bus.pi       = pi;
  assign bus.pt       = pt;
  assign bus.i_reg    = i_reg;
  assign bus.in_irq   = in_irq;
  assign bus.irq_ack  = irq_ack;

endmodule

// File: doc/jtdsp16_pcseq.md
# jtdsp16_pcseq

Program sequencer (XAAU execution side) for the JTDSP16 core. It consumes the registered control strobes and instruction fields from the instruction decoder, owns PC, PR, PI, PT and I, drives the program ROM address, and accepts external interrupts. It sits between the program ROM and the decoder, closing the fetch loop.

## Interface
Parameters:
- RST_VEC, 16'h0000, PC value after reset
- IRQ_VEC, 16'h0001, PC loaded on interrupt entry

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- cen  in  1  clock enable; all state updates are qualified by it
- goto_ja  in  1  jump: PC <= {PC[15:12], i_field}
- call_ja  in  1  call: PR <= PC, then jump as goto_ja
- goto_b  in  1  B-type jump, subtype in b_field
- b_field  in  3  0 return (PC<=PR), 1 ireturn (PC<=PI), 2 goto PT, 3 call PT (PR<=PC, PC<=PT), 4-7 no operation
- i_field  in  12  jump target, low bits
- pc_halt  in  1  hold PC for one cen cycle (data-memory access)
- imm_load  in  1  load selected register from load_data
- ram_load  in  1  same as imm_load, data returned from RAM
- r_field  in  3  0 PT, 1 PR, 2 PI, 3 I, 4-7 ignored
- load_data  in  16  value for imm_load/ram_load
- pt_inc  in  1  PT <= PT + sext(I)
- irq  in  1  external interrupt request, level sensitive
- rom_addr  out  16  program ROM address, equal to PC
- pr, pi, pt  out  16  register contents
- i_reg  out  12  increment register
- in_irq  out  1  high while the interrupt service routine runs
- irq_ack  out  1  one-cen-cycle pulse on interrupt entry

## Operation
- Reset (asynchronous, rst_n low): PC=RST_VEC, PR=PI=PT=0, I=0, in_irq=0, irq_ack=0, slot=0.
- PC update priority on each cen: jump (goto_ja, call_ja, goto_b with b_field 0-3) > interrupt entry > pc_halt > PC+1 (wraps 16'hFFFF to 0).
- Simultaneous goto_ja/call_ja/goto_b: priority call_ja > goto_ja > goto_b. The decoder never issues these together. The bench checks this priority only as a robustness case.
- Call: PR takes the pre-update PC, which is the return address.
- ireturn clears in_irq in the same cycle that PC <= PI.
- Internal flag slot is set for one cen cycle after any jump, because the word fetched in that slot is discarded by the decoder.
- Interrupt entry happens when all of the following hold: irq=1, in_irq=0, slot=0, and no jump or pc_halt is active this cycle. On entry: PI <= PC, PC <= IRQ_VEC, in_irq <= 1, irq_ack <= 1 for one cen cycle. Requests are not latched. A request that is dropped before it is accepted is lost.
- Register loads (imm_load or ram_load) write to the register selected by r_field. I takes load_data[11:0]. A load proceeds independently of jumps.
- Load vs. call conflicts: a load of PR in the same cycle as a call is overridden by the call. A load of PI in the same cycle as interrupt entry is overridden by the entry.
- PT arithmetic: PT + {{4{I[11]}}, I} modulo 2^16. A load to PT in the same cycle has priority over pt_inc.

## Timing
- Every output is registered. rom_addr changes one cen edge after the strobe.
- Jump latency: strobe sampled at edge n, rom_addr equals the target after edge n.
- pc_halt: PC holds for exactly the strobed cycle, then increments again.
- With cen low, all state holds and irq_ack stays at its value. irq_ack is cleared on the next cen edge.
- Asserting reset mid-operation clears all state immediately. The first fetch after rst_n rises is RST_VEC.

## Structure
- Shared package jtdsp16_pkg holds:
  - b_field encodings (B_RET, B_IRET, B_GOPT, B_CALLPT);
  - r_field encodings (XR_PT, XR_PR, XR_PI, XR_I);
  - the default vectors.
- No sub-module is required. The PT adder may be split out as jtdsp16_ptadd if it is reused by the table-read path.

## Test plan
- Reset: hold rst_n low, release, run 3 cen cycles -> rom_addr 0,1,2,3.
- call_ja with PC=16'h1234 and i_field=12'h056, then goto_b return -> PR=16'h1234, rom_addr=16'h1056, then back to 16'h1234.
- irq raised while PC=16'h0200 with no strobes -> PI=16'h0200, rom_addr=16'h0001, single irq_ack pulse, in_irq=1. A second irq is ignored. ireturn -> rom_addr=16'h0200, in_irq=0.
- irq held through a goto_ja cycle and its slot -> entry deferred to the cycle after the slot, PI equals the jump target+1.
- Load I=12'hFFE and PT=16'h0001, then two pt_inc -> PT=16'hFFFF then 16'hFFFD (wrap checked).
- pc_halt for one cycle, and a simultaneous imm_load of PR plus call_ja -> PC holds once, and PR takes the call value rather than load_data.
